// File: rtl/shifter_right_seq.sv
// Sequential sign-magnitude arithmetic right shifter, one magnitude bit per clock.
// Define SHR_ROUND_EN for round-half-away-from-zero; otherwise truncates toward zero.
module shifter_right_seq #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_out,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ERR,
    output logic         o_lost
);

    localparam int MW = N - 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [MW-1:0]  mag;
    logic [CW-1:0]  count;
    logic           sign;

    logic [MW-1:0]  b_mag;
    logic [CW-1:0]  k_clamp;
    logic           last_shift;
    logic           guard;
    logic [MW-1:0]  mag_sh;
    logic [MW-1:0]  mag_fin;

    assign b_mag      = i_b[MW-1:0];
    assign k_clamp    = (b_mag > MW'(N)) ? CW'(N) : CW'(b_mag);
    assign last_shift = (count == CW'(1));
    // bit leaving the magnitude on this shift edge
    assign guard      = mag[0];
    assign mag_sh     = mag >> 1;

`ifdef SHR_ROUND_EN
    assign mag_fin = mag_sh + MW'(guard);
`else
    assign mag_fin = mag_sh;
`endif

    function automatic logic [N-1:0] pack_out(
        input logic          s,
        input logic [MW-1:0] m
    );
        return (m == '0) ? '0 : {s, m};
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_b[N-1] || (k_clamp == '0)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
        o_done = (state == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mag    <= '0;
            count  <= '0;
            sign   <= 1'b0;
            o_out  <= '0;
            o_ERR  <= 1'b0;
            o_lost <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_lost <= 1'b0;
                        if (i_b[N-1]) begin
                            o_ERR <= 1'b1;
                            o_out <= '0;
                            mag   <= '0;
                            sign  <= 1'b0;
                            count <= '0;
                        end else begin
                            o_ERR <= 1'b0;
                            mag   <= i_a[MW-1:0];
                            sign  <= i_a[N-1];
                            count <= k_clamp;
                            if (k_clamp == '0) begin
                                o_out <= pack_out(i_a[N-1], i_a[MW-1:0]);
                            end
                        end
                    end
                end
                SHIFT: begin
                    mag    <= mag_sh;
                    count  <= count - CW'(1);
                    o_lost <= o_lost | guard;
                    if (last_shift) begin
                        o_out <= pack_out(sign, mag_fin);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_right_seq.sv
// Randomized and directed bench for shifter_right_seq against an arithmetic model.
module tb_shifter_right_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] out;
    logic         busy;
    logic         done;
    logic         err;
    logic         lost;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shifter_right_seq #(.N(N)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_a    (a),
        .i_b    (b),
        .o_out  (out),
        .o_busy (busy),
        .o_done (done),
        .o_ERR  (err),
        .o_lost (lost)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // result = |a| / 2^k with k clamped to N, sign kept unless result is zero
    function automatic void model(
        input  logic [N-1:0] ma,
        input  logic [N-1:0] mb,
        output logic [N-1:0] eo,
        output logic         ee,
        output logic         el,
        output int           ek
    );
        int m;
        int k;
        int r;
        if (mb[N-1]) begin
            eo = '0;
            ee = 1'b1;
            el = 1'b0;
            ek = 0;
            return;
        end
        m = int'(ma[N-2:0]);
        k = int'(mb[N-2:0]);
        if (k > N) k = N;
        r = m / (1 << k);
        el = (m % (1 << k)) != 0;
`ifdef SHR_ROUND_EN
        if (k > 0 && ((m / (1 << (k - 1))) % 2) == 1) r = r + 1;
`endif
        ee = 1'b0;
        ek = k;
        eo = (r == 0) ? '0 : {ma[N-1], 7'(r)};
    endfunction

    task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                          input bit glitch, input logic [N-1:0] ga);
        logic [N-1:0] eo;
        logic         ee;
        logic         el;
        int           ek;
        int           n;
        model(va, vb, eo, ee, el, ek);
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = glitch;
        if (glitch) begin
            a = ga;
            b = 8'h01;
        end
        n = 0;
        while (!done && n < 40) begin
            check("busy_run", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check("latency", n, ek);
        check("done", 32'(done), 32'd1);
        check("out", 32'(out), 32'(eo));
        check("err", 32'(err), 32'(ee));
        check("lost", 32'(lost), 32'(el));
        check("busy_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("out_hold", 32'(out), 32'(eo));
    endtask

    initial begin
        int seen;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        rst = 1'b0;

        run_op(8'h0D, 8'h02, 1'b0, 8'h00);
        run_op(8'h8B, 8'h01, 1'b0, 8'h00);
        run_op(8'h55, 8'h85, 1'b0, 8'h00);
        run_op(8'h55, 8'h80, 1'b0, 8'h00);
        run_op(8'h55, 8'h01, 1'b0, 8'h00);
        run_op(8'h7F, 8'h0A, 1'b0, 8'h00);
        run_op(8'h7F, 8'h08, 1'b0, 8'h00);
        run_op(8'h81, 8'h01, 1'b0, 8'h00);
        run_op(8'hA5, 8'h00, 1'b0, 8'h00);
        run_op(8'h80, 8'h00, 1'b0, 8'h00);
        run_op(8'h40, 8'h03, 1'b1, 8'h7F);

        // reset in the middle of a shift sequence
        @(negedge clk);
        start = 1'b1;
        a     = 8'h70;
        b     = 8'h05;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out", 32'(out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_lost", 32'(lost), 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_nodone", seen, 0);
        run_op(8'h70, 8'h05, 1'b0, 8'h00);

        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) rb[N-1] = 1'b1;
            if ($urandom_range(0, 5) == 0) rb[N-2:0] = 7'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
